// File: rtl/ex_mem_reg.sv
// ex_mem_reg: pipeline register between the execute and memory stages.
//
// Holds one execute-stage result in a slot register. The slot stays
// unchanged for as long as a memory op waits on the data bus. Upstream
// stages are stalled until the bus returns data_ok. The block also flags
// which cycles carry a retiring instruction and counts the bus-stall cycles.
//
// Ports:
//   clk        in   clock, single domain
//   reset      in   synchronous, active-low reset
//   dataE_in   in   execute-stage result for this cycle
//   flush      in   squash request; kills the next entry loaded into the slot
//   dresp      in   data-bus response (only data_ok is consumed)
//   dataE      out  slot contents, fed to the memory stage
//   stall_out  out  freeze fetch/decode/execute this cycle
//   mem_valid  out  memory stage output is a retiring instruction this cycle
//   stall_cnt  out  saturating count of cycles with stall_out high

package ex_mem_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_LD  = 3'd5,
        OP_SD  = 3'd6,
        OP_BR  = 3'd7
    } op_t;

    typedef struct packed {
        op_t        op;
        logic [4:0] dst;
        logic       wen;
    } ctl_t;

    // is_bubble is the MSB; the reset constant in ex_mem_reg relies on that.
    typedef struct packed {
        logic        is_bubble;
        logic [31:0] pc;
        ctl_t        ctl;
        logic [63:0] alu_result;
        logic [63:0] store_data;
    } execute_data_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] rdata;
    } dbus_resp_t;

endpackage

// state   | meaning
// --------+--------------------------------------------------------------
// EMPTY   | slot holds a bubble; loads the next entry every cycle
// PASS    | slot holds a valid non-memory op; retires and is replaced
// WAIT    | slot holds a valid LD/SD; held until the data_ok cycle
//
// The state is decoded from the slot register itself, so the slot is the
// state register. The slot load follows the same decode.
module ex_mem_reg
    import ex_mem_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  execute_data_t     dataE_in,
    input  logic              flush,
    input  dbus_resp_t        dresp,
    output execute_data_t     dataE,
    output logic              stall_out,
    output logic              mem_valid,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PASS  = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam execute_data_t SLOT_RESET =
        execute_data_t'({1'b1, {($bits(execute_data_t)-1){1'b0}}});
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    execute_data_t    slot_q, slot_d;
    execute_data_t    next_entry;
    logic             flush_pending_q, flush_pending_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    state_t           state;
    logic             load;

    // Only data_ok matters here; the rest of the response belongs to MEM.
    logic unused_dresp;
    assign unused_dresp = ^{dresp.addr_ok, dresp.rdata};

    always_comb begin
        if (slot_q.is_bubble) begin
            state = ST_EMPTY;
        end else if (slot_q.ctl.op == OP_LD || slot_q.ctl.op == OP_SD) begin
            state = ST_WAIT;
        end else begin
            state = ST_PASS;
        end
    end

    always_comb begin
        stall_out = 1'b0;
        mem_valid = 1'b0;
        load      = 1'b1;
        case (state)
            ST_EMPTY: begin
                mem_valid = 1'b0;
            end
            ST_PASS: begin
                mem_valid = 1'b1;
            end
            ST_WAIT: begin
                // Bus response goes straight to the outputs, so a
                // same-cycle data_ok adds no stall.
                stall_out = ~dresp.data_ok;
                mem_valid = dresp.data_ok;
                load      = dresp.data_ok;
            end
            default: begin
                load = 1'b1;
            end
        endcase
    end

    always_comb begin
        next_entry           = dataE_in;
        next_entry.is_bubble = dataE_in.is_bubble | flush | flush_pending_q;

        slot_d = load ? next_entry : slot_q;

        // A flush seen while holding is remembered until the load that it
        // kills. A flush in the loading cycle acts directly through next_entry.
        flush_pending_d = load ? 1'b0 : (flush_pending_q | flush);

        stall_cnt_d = stall_cnt_q;
        if (stall_out && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_q          <= SLOT_RESET;
            flush_pending_q <= 1'b0;
            stall_cnt_q     <= '0;
        end else begin
            slot_q          <= slot_d;
            flush_pending_q <= flush_pending_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    assign dataE     = slot_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;
    import ex_mem_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    execute_data_t dataE_in;
    logic          flush;
    dbus_resp_t    dresp;
    execute_data_t dataE;
    logic          stall_out;
    logic          mem_valid;
    logic [3:0]    stall_cnt;

    int vecs = 0;
    int errs = 0;
    execute_data_t exp_q[$];

    ex_mem_reg #(.CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .dataE_in  (dataE_in),
        .flush     (flush),
        .dresp     (dresp),
        .dataE     (dataE),
        .stall_out (stall_out),
        .mem_valid (mem_valid),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic execute_data_t mk(input op_t op, input logic [31:0] pc,
                                         input logic [63:0] res);
        execute_data_t d;
        d            = '0;
        d.pc         = pc;
        d.ctl.op     = op;
        d.ctl.dst    = pc[6:2];
        d.ctl.wen    = (op != OP_SD);
        d.alu_result = res;
        d.store_data = {32'hCAFE_0000, pc};
        return d;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chk_cnt(input string nm, input logic [3:0] act, input int exp);
        vecs++;
        if (act !== exp[3:0]) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_slot(input string nm, input execute_data_t exp);
        vecs++;
        if (dataE !== exp) begin
            errs++;
            $display("FAIL %s: dataE got %h expected %h", nm, dataE, exp);
        end
    endtask

    // Drive inputs for one cycle just after the rising edge, then check the
    // combinational outputs and the counter mid-cycle.
    task automatic cyc(input string tag, input execute_data_t din, input logic rst,
                       input logic fl, input logic dok, input logic es,
                       input logic emv, input int ecnt);
        @(posedge clk);
        #1;
        dataE_in      = din;
        reset         = rst;
        flush         = fl;
        dresp.data_ok = dok;
        @(negedge clk);
        chk1({tag, " stall_out"}, stall_out, es);
        chk1({tag, " mem_valid"}, mem_valid, emv);
        chk_cnt({tag, " stall_cnt"}, stall_cnt, ecnt);
    endtask

    // Scoreboard monitor: every retiring cycle must match the next expected entry.
    always @(negedge clk) begin
        if (mem_valid === 1'b1) begin
            vecs++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL retire: unexpected mem_valid with dataE %h", dataE);
            end else begin
                execute_data_t e;
                e = exp_q.pop_front();
                if (dataE !== e) begin
                    errs++;
                    $display("FAIL retire: dataE got %h expected %h", dataE, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        execute_data_t add1, add2, add3, add4, add5, add6, add7, add8, add9;
        execute_data_t ld1, ld2, ld3, ld4, ld5, sd1, bub;
        add1 = mk(OP_ADD, 32'h0000_0100, 64'd11);
        ld1  = mk(OP_LD,  32'h0000_0104, 64'h0000_0000_8000_1000);
        add2 = mk(OP_ADD, 32'h0000_0108, 64'd22);
        sd1  = mk(OP_SD,  32'h0000_010C, 64'h0000_0000_8000_2000);
        add3 = mk(OP_SUB, 32'h0000_0110, 64'd33);
        ld2  = mk(OP_LD,  32'h0000_0114, 64'h0000_0000_8000_3000);
        add4 = mk(OP_ADD, 32'h0000_0118, 64'd44);
        add5 = mk(OP_OR,  32'h0000_011C, 64'd55);
        ld3  = mk(OP_LD,  32'h0000_0120, 64'h0000_0000_8000_4000);
        add6 = mk(OP_ADD, 32'h0000_0124, 64'd66);
        add7 = mk(OP_AND, 32'h0000_0128, 64'd77);
        ld4  = mk(OP_LD,  32'h0000_012C, 64'h0000_0000_8000_5000);
        add8 = mk(OP_ADD, 32'h0000_0130, 64'd88);
        ld5  = mk(OP_SD,  32'h0000_0134, 64'h0000_0000_8000_6000);
        add9 = mk(OP_ADD, 32'h0000_0200, 64'd99);
        bub  = mk(OP_NOP, 32'h0, 64'h0);
        bub.is_bubble = 1'b1;

        reset    = 1'b0;
        flush    = 1'b0;
        dresp    = '0;
        dataE_in = add1;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk1("rst is_bubble", dataE.is_bubble, 1'b1);
            chk1("rst stall_out", stall_out, 1'b0);
            chk1("rst mem_valid", mem_valid, 1'b0);
            chk_cnt("rst stall_cnt", stall_cnt, 0);
        end

        exp_q.push_back(add1);
        cyc("release", add1, 1, 0, 0, 0, 0, 0);
        chk1("release bubble", dataE.is_bubble, 1'b1);

        exp_q.push_back(ld1);
        cyc("add1", ld1, 1, 0, 0, 0, 1, 0);
        chk_slot("add1 slot", add1);

        exp_q.push_back(add2);
        for (int i = 0; i < 3; i++) begin
            cyc("ld1_wait", add2, 1, 0, 0, 1, 0, i);
            chk_slot("ld1_wait slot", ld1);
        end
        cyc("ld1_ok", add2, 1, 0, 1, 0, 1, 3);
        chk_slot("ld1_ok slot", ld1);

        exp_q.push_back(sd1);
        cyc("add2", sd1, 1, 0, 0, 0, 1, 3);
        chk_slot("add2 slot", add2);

        exp_q.push_back(add3);
        cyc("sd_same", add3, 1, 0, 1, 0, 1, 3);
        chk_slot("sd_same slot", sd1);

        exp_q.push_back(ld2);
        cyc("add3", ld2, 1, 0, 0, 0, 1, 3);

        cyc("fl_w0", add4, 1, 0, 0, 1, 0, 3);
        cyc("fl_pulse", add4, 1, 1, 0, 1, 0, 4);
        cyc("fl_w2", add4, 1, 0, 0, 1, 0, 5);
        chk_slot("fl_w2 slot", ld2);
        cyc("fl_ok", add4, 1, 0, 1, 0, 1, 6);

        exp_q.push_back(add5);
        cyc("fl_bubble", add5, 1, 0, 0, 0, 0, 6);
        chk1("fl_bubble is_bubble", dataE.is_bubble, 1'b1);

        exp_q.push_back(ld3);
        cyc("add5", ld3, 1, 0, 0, 0, 1, 6);
        chk_slot("add5 slot", add5);

        cyc("ld3_wait", add6, 1, 0, 0, 1, 0, 6);
        cyc("fl_dok", add6, 1, 1, 1, 0, 1, 7);

        exp_q.push_back(add7);
        cyc("fd_bubble", add7, 1, 0, 0, 0, 0, 7);
        chk1("fd_bubble is_bubble", dataE.is_bubble, 1'b1);

        exp_q.push_back(ld4);
        cyc("add7", ld4, 1, 0, 0, 0, 1, 7);
        chk_slot("add7 slot", add7);

        exp_q.push_back(add8);
        for (int i = 0; i < 20; i++) begin
            cyc("sat_wait", add8, 1, 0, 0, 1, 0, (7 + i > 15) ? 15 : 7 + i);
        end
        cyc("sat_ok", add8, 1, 0, 1, 0, 1, 15);

        cyc("add8", ld5, 1, 0, 0, 0, 1, 15);
        chk_slot("add8 slot", add8);

        cyc("abort_wait", add9, 1, 0, 0, 1, 0, 15);
        cyc("abort_rst", add9, 0, 0, 0, 1, 0, 15);

        exp_q.push_back(add9);
        cyc("abort_empty", add9, 1, 0, 1, 0, 0, 0);
        chk1("abort_empty is_bubble", dataE.is_bubble, 1'b1);

        cyc("add9_dok", bub, 1, 0, 1, 0, 1, 0);
        chk_slot("add9 slot", add9);

        cyc("tail", bub, 1, 0, 0, 0, 0, 0);

        vecs++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL drain: %0d expected retirements never seen, 0 required",
                     exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
